// File: rtl/lzw_pkg.sv
// rtl/lzw_pkg.sv - shared LZW datapath defaults and conflict-table policy constants
package lzw_pkg;

  localparam int LZW_DATA_WIDTH = 64;
  localparam int LZW_HASH_WIDTH = 11;

  localparam bit CT_WRAP   = 1'b1;
  localparam bit CT_REJECT = 1'b0;

  typedef enum logic [2:0] {
    WR_NONE,
    WR_UPDATE,
    WR_INSERT,
    WR_REPLACE,
    WR_DROP
  } wr_act_e;

endpackage

// File: rtl/conflict_cam_if.sv
// rtl/conflict_cam_if.sv - request/response bundle between the compressor and the conflict table
interface conflict_cam_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 64,
  parameter int HASH_WIDTH = 11
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  wr_en;
  logic                  lk_en;
  logic [DATA_WIDTH-1:0] data;
  logic [HASH_WIDTH-1:0] hash_in;
  logic [HASH_WIDTH-1:0] map_in;
  logic                  lk_valid;
  logic                  match;
  logic [HASH_WIDTH-1:0] hash_out;
  logic [HASH_WIDTH-1:0] map_out;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  wr_drop;

  modport master (
    output flush, wr_en, lk_en, data, hash_in, map_in,
    input  lk_valid, match, hash_out, map_out, count, full, wr_drop
  );

  modport slave (
    input  flush, wr_en, lk_en, data, hash_in, map_in,
    output lk_valid, match, hash_out, map_out, count, full, wr_drop
  );

endinterface

// File: rtl/prio_enc.sv
// rtl/prio_enc.sv - lowest-set-bit priority encoder with any-hit flag
module prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int IW = $clog2(N);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx   = '0;
    found = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/conflict_cam.sv
// rtl/conflict_cam.sv - fully associative LZW hash-conflict table with registered lookup
module conflict_cam
  import lzw_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = LZW_DATA_WIDTH,
  parameter int HASH_WIDTH = LZW_HASH_WIDTH,
  parameter bit WRAP       = CT_WRAP
) (
  input  logic           clk,
  input  logic           rst,
  conflict_cam_if.slave  cam
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]      valid_q, valid_d, hit;
  logic [DATA_WIDTH-1:0] key_q  [DEPTH];
  logic [DATA_WIDTH-1:0] key_d  [DEPTH];
  logic [HASH_WIDTH-1:0] hash_q [DEPTH];
  logic [HASH_WIDTH-1:0] hash_d [DEPTH];
  logic [HASH_WIDTH-1:0] map_q  [DEPTH];
  logic [HASH_WIDTH-1:0] map_d  [DEPTH];
  logic [IW-1:0]         wr_ptr_q, wr_ptr_d, hit_idx, wr_idx;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  lk_valid_q, lk_valid_d;
  logic                  match_q, match_d;
  logic                  wr_drop_q, wr_drop_d;
  logic [HASH_WIDTH-1:0] hash_out_q, hash_out_d;
  logic [HASH_WIDTH-1:0] map_out_q, map_out_d;
  logic                  hit_any;
  wr_act_e               act;

  // One compare array serves both the lookup and the write duplicate check.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid_q[i] && (key_q[i] == cam.data);
    end
  end

  prio_enc #(.N(DEPTH)) u_prio (
    .req   (hit),
    .idx   (hit_idx),
    .found (hit_any)
  );

  always_comb begin
    act = WR_NONE;
    if (!cam.flush && cam.wr_en) begin
      if (hit_any)      act = WR_UPDATE;
      else if (!full_q) act = WR_INSERT;
      else if (WRAP)    act = WR_REPLACE;
      else              act = WR_DROP;
    end
    wr_idx = (act == WR_UPDATE) ? hit_idx : wr_ptr_q;
  end

  always_comb begin
    valid_d   = valid_q;
    key_d     = key_q;
    hash_d    = hash_q;
    map_d     = map_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_drop_d = (act == WR_DROP);

    case (act)
      WR_UPDATE: begin
        hash_d[wr_idx] = cam.hash_in;
        map_d[wr_idx]  = cam.map_in;
      end
      WR_INSERT, WR_REPLACE: begin
        valid_d[wr_idx] = 1'b1;
        key_d[wr_idx]   = cam.data;
        hash_d[wr_idx]  = cam.hash_in;
        map_d[wr_idx]   = cam.map_in;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      default: ;
    endcase

    if (act == WR_INSERT) count_d = count_q + 1'b1;

    if (cam.flush) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    full_d = (count_d == CW'(DEPTH));

    // Lookup samples pre-write contents; the write lands on the same edge.
    lk_valid_d = cam.lk_en && !cam.flush;
    match_d    = lk_valid_d && hit_any;
    hash_out_d = hash_out_q;
    map_out_d  = map_out_q;
    if (lk_valid_d) begin
      hash_out_d = hit_any ? hash_q[hit_idx] : '0;
      map_out_d  = hit_any ? map_q[hit_idx]  : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      lk_valid_q <= 1'b0;
      match_q    <= 1'b0;
      wr_drop_q  <= 1'b0;
      hash_out_q <= '0;
      map_out_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      lk_valid_q <= lk_valid_d;
      match_q    <= match_d;
      wr_drop_q  <= wr_drop_d;
      hash_out_q <= hash_out_d;
      map_out_q  <= map_out_d;
    end
  end

  // Payload storage is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    hash_q <= hash_d;
    map_q  <= map_d;
  end

  assign cam.lk_valid = lk_valid_q;
  assign cam.match    = match_q;
  assign cam.hash_out = hash_out_q;
  assign cam.map_out  = map_out_q;
  assign cam.count    = count_q;
  assign cam.full     = full_q;
  assign cam.wr_drop  = wr_drop_q;

endmodule
